// File: rtl/m_rv32.sv
// Shared rv32 core definitions: CSR operation encoding and
// performance-monitor CSR address bases.
package m_rv32;

  typedef enum logic [1:0] {
    CSR_N = 2'd0,
    CSR_W = 2'd1,
    CSR_S = 2'd2,
    CSR_C = 2'd3
  } csr_op_t;

  localparam logic [11:0] CSR_MHPM_LO = 12'hB00;
  localparam logic [11:0] CSR_MHPM_HI = 12'hB80;
  localparam logic [11:0] CSR_HPM_LO = 12'hC00;
  localparam logic [11:0] CSR_HPM_HI = 12'hC80;
  localparam logic [11:0] CSR_MCNTINH = 12'h320;
  localparam logic [11:0] CSR_MHPMEVT = 12'h323;
  localparam logic [11:0] CSR_MCNTOVF = 12'h7C0;

  // Counter slot j -> architectural counter number (skips time).
  function automatic int ctr_bit(input int j);
    return (j == 0) ? 0 : j + 1;
  endfunction

  function automatic logic [31:0] ctr_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < n + 2; j++)
      m[ctr_bit(j)] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hpm_ctr.sv
// One performance counter: half-word writable, +1 per enabled
// cycle, wrap pulse when an increment rolls all-ones to zero.
module hpm_ctr #(
  parameter int CTR_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CTR_W-1:0] count,
  output logic             wrap
);

  logic en;

  // A write to either half swallows this cycle's increment.
  assign en = inc & ~inhibit & ~wr_lo & ~wr_hi;
  assign wrap = en & (&count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= wdata;
    end else if (wr_hi) begin
      count[CTR_W-1:32] <= wdata[CTR_W-33:0];
    end else if (en) begin
      count <= count + CTR_W'(1);
    end
  end

endmodule

// File: rtl/hpm_csr.sv
// Hardware performance-monitor CSR file: cycle, instret and
// programmable event counters with inhibit and sticky overflow.
module hpm_csr
  import m_rv32::*;
#(
  parameter int NUM_CTR = 4,
  parameter int NUM_EVT = 8,
  parameter int CTR_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_ret,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [11:0]        csr_addr,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_out,
  output logic               csr_illegal,
  output logic               irq_ovf
);

  localparam int NCNT = NUM_CTR + 2;
  localparam logic [31:0] INH_MASK = ctr_mask(NUM_CTR);

  logic [CTR_W-1:0]  cnt [NCNT];
  logic [NCNT-1:0]   wrap;
  logic [NCNT-1:0]   wr_lo;
  logic [NCNT-1:0]   wr_hi;
  logic [NCNT-1:0]   inc_src;
  logic [NUM_CTR-1:0] evt_hit;
  logic [7:0]        sel [NUM_CTR];
  logic [31:0]       inhibit;
  logic [31:0]       ovf;
  logic [31:0]       ovf_set;
  logic [31:0]       ovf_clr;
  logic [31:0]       ovf_nxt;
  logic [31:0]       wval;
  logic [31:0]       hi_v;
  logic [CTR_W-1:0]  cnt_sel;
  logic [7:0]        sel_rd;
  logic [4:0]        pg;
  logic [6:0]        off;
  logic              off_ok;
  logic              ro;
  logic              ctr_lo;
  logic              ctr_hi;
  logic              is_inh;
  logic              is_evt;
  logic              is_ovf;
  logic              wr;
  int                slot;
  int                eidx;

  // Address decode
  assign pg = csr_addr[11:7];
  assign off = csr_addr[6:0];
  assign off_ok = (off == 7'd0) ||
    (off >= 7'd2 && off <= 7'(2 + NUM_CTR));
  assign ro = (pg == CSR_HPM_LO[11:7]) ||
    (pg == CSR_HPM_HI[11:7]);
  assign ctr_lo = off_ok &&
    (pg == CSR_MHPM_LO[11:7] || pg == CSR_HPM_LO[11:7]);
  assign ctr_hi = off_ok &&
    (pg == CSR_MHPM_HI[11:7] || pg == CSR_HPM_HI[11:7]);
  assign is_inh = csr_addr == CSR_MCNTINH;
  assign is_evt = csr_addr >= CSR_MHPMEVT &&
    csr_addr < CSR_MHPMEVT + 12'(NUM_CTR);
  assign is_ovf = csr_addr == CSR_MCNTOVF;
  assign slot = (off == 7'd0) ? 0 : int'(off) - 1;
  assign eidx = int'(csr_addr - CSR_MHPMEVT);
  assign wr = csr_we && (csr_op_t'(csr_op) != CSR_N);

  always_comb begin
    cnt_sel = '0;
    sel_rd = '0;
    for (int j = 0; j < NCNT; j++)
      if (slot == j) cnt_sel = cnt[j];
    for (int i = 0; i < NUM_CTR; i++)
      if (eidx == i) sel_rd = sel[i];
    hi_v = '0;
    hi_v[CTR_W-33:0] = cnt_sel[CTR_W-1:32];
  end

  // Read mux
  always_comb begin
    csr_out = '0;
    csr_illegal = 1'b0;
    unique case (1'b1)
      ctr_lo: csr_out = cnt_sel[31:0];
      ctr_hi: csr_out = hi_v;
      is_inh: csr_out = inhibit;
      is_evt: csr_out = {24'd0, sel_rd};
      is_ovf: csr_out = ovf;
      default: csr_illegal = 1'b1;
    endcase
    if (csr_we && ro && (ctr_lo || ctr_hi))
      csr_illegal = 1'b1;
  end

  always_comb begin
    unique case (csr_op_t'(csr_op))
      CSR_W: wval = csr_wdata;
      CSR_S: wval = csr_out | csr_wdata;
      CSR_C: wval = csr_out & ~csr_wdata;
      default: wval = csr_out;
    endcase
  end

  // Event selection: 0 and out-of-range selectors count nothing
  always_comb begin
    evt_hit = '0;
    for (int i = 0; i < NUM_CTR; i++)
      for (int k = 0; k < NUM_EVT; k++)
        if (sel[i] == 8'(k + 1)) evt_hit[i] = evt[k];
  end

  assign inc_src = {evt_hit, inst_ret, 1'b1};

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int j = 0; j < NCNT; j++) begin
      wr_lo[j] = wr && !ro && ctr_lo && slot == j;
      wr_hi[j] = wr && !ro && ctr_hi && slot == j;
    end
  end

  for (genvar j = 0; j < NCNT; j++) begin : g_ctr
    hpm_ctr #(
      .CTR_W(CTR_W)
    ) u_ctr (
      .clk(clk),
      .rst_n(rst_n),
      .inc(inc_src[j]),
      .inhibit(inhibit[ctr_bit(j)]),
      .wr_lo(wr_lo[j]),
      .wr_hi(wr_hi[j]),
      .wdata(wval),
      .count(cnt[j]),
      .wrap(wrap[j])
    );
  end

  // Set beats a same-cycle W1C clear
  always_comb begin
    ovf_set = '0;
    for (int j = 0; j < NCNT; j++)
      ovf_set[ctr_bit(j)] = wrap[j];
    ovf_clr = (wr && is_ovf) ? wval : '0;
    ovf_nxt = (ovf & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit <= '0;
      ovf <= '0;
      irq_ovf <= 1'b0;
      for (int i = 0; i < NUM_CTR; i++)
        sel[i] <= '0;
    end else begin
      ovf <= ovf_nxt;
      irq_ovf <= |ovf_nxt;
      if (wr && is_inh)
        inhibit <= wval & INH_MASK;
      for (int i = 0; i < NUM_CTR; i++)
        if (wr && is_evt && eidx == i)
          sel[i] <= wval[7:0];
    end
  end

endmodule

// File: tb/tb_hpm_csr.sv
// Scoreboard bench for hpm_csr: stimulus queues expected reads,
// a negedge monitor pops and compares.
module tb_hpm_csr;
  import m_rv32::*;

  typedef struct {
    logic [31:0] d;
    logic        ill;
    logic        irq;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        inst_ret;
  logic [7:0]  evt;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_out;
  logic        csr_illegal;
  logic        irq_ovf;

  exp_t sb[$];
  bit   chk;
  bit   irq_m;
  int   checks;
  int   errors;

  hpm_csr #(
    .NUM_CTR(4),
    .NUM_EVT(8),
    .CTR_W(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_ret(inst_ret),
    .evt(evt),
    .csr_addr(csr_addr),
    .csr_we(csr_we),
    .csr_op(csr_op),
    .csr_wdata(csr_wdata),
    .csr_out(csr_out),
    .csr_illegal(csr_illegal),
    .irq_ovf(irq_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: monitor fired with no expectation");
      end else begin
        e = sb.pop_front();
        if (csr_out !== e.d || csr_illegal !== e.ill ||
            irq_ovf !== e.irq) begin
          errors++;
          $display("FAIL %s: got data=%h ill=%b irq=%b exp data=%h ill=%b irq=%b",
                   e.nm, csr_out, csr_illegal, irq_ovf, e.d, e.ill, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [11:0] a, input logic we,
                     input logic [1:0] op, input logic [31:0] wd,
                     input logic [7:0] ev, input logic ir,
                     input bit ce, input logic [31:0] ed,
                     input logic ei, input string nm);
    exp_t e;
    csr_addr = a;
    csr_we = we;
    csr_op = op;
    csr_wdata = wd;
    evt = ev;
    inst_ret = ir;
    if (ce) begin
      e.d = ed;
      e.ill = ei;
      e.irq = irq_m;
      e.nm = nm;
      sb.push_back(e);
      chk = 1'b1;
    end
    @(posedge clk);
    #1;
    csr_we = 1'b0;
    csr_op = 2'd0;
    evt = '0;
    inst_ret = 1'b0;
    chk = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d,
                    input logic ill, input string nm);
    cyc(a, 1'b0, 2'd0, 32'd0, 8'd0, 1'b0, 1'b1, d, ill, nm);
  endtask

  task automatic wr(input logic [11:0] a, input csr_op_t op,
                    input logic [31:0] d);
    cyc(a, 1'b1, op, d, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic pulse(input logic [7:0] ev);
    cyc(12'h000, 1'b0, 2'd0, 32'd0, ev, 1'b0, 1'b0, 32'd0, 1'b0, "");
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ret = 1'b0;
    evt = '0;
    csr_addr = '0;
    csr_we = 1'b0;
    csr_op = 2'd0;
    csr_wdata = '0;
    chk = 1'b0;
    irq_m = 1'b0;
    checks = 0;
    errors = 0;
    repeat (2) @(posedge clk);
    #1;
    rd(12'hB00, 32'd0, 1'b0, "rst_cycle");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) pulse(8'd0);
    rd(12'hC00, 32'd10, 1'b0, "idle_cycle");
    rd(12'hC02, 32'd0, 1'b0, "idle_instret");
    rd(12'h7C0, 32'd0, 1'b0, "idle_ovf");

    for (int i = 0; i < 3; i++)
      cyc(12'h000, 1'b0, 2'd0, 32'd0, 8'd0, 1'b1, 1'b0, 32'd0, 1'b0, "");
    rd(12'hC02, 32'd3, 1'b0, "instret3");

    wr(12'h323, CSR_W, 32'd2);
    for (int i = 0; i < 5; i++) pulse(8'h02);
    for (int i = 0; i < 3; i++) pulse(8'h01);
    rd(12'hB03, 32'd5, 1'b0, "hpm3_count");
    rd(12'h323, 32'd2, 1'b0, "sel3");
    wr(12'h320, CSR_S, 32'd8);
    for (int i = 0; i < 2; i++) pulse(8'h02);
    rd(12'hB03, 32'd5, 1'b0, "hpm3_inhibited");
    rd(12'h320, 32'd8, 1'b0, "inh_set");
    wr(12'h320, CSR_W, 32'hFFFF_FFFF);
    rd(12'h320, 32'h7D, 1'b0, "inh_mask");
    wr(12'h320, CSR_W, 32'd0);
    wr(12'h324, CSR_W, 32'h1FF);
    rd(12'h324, 32'hFF, 1'b0, "sel4_oor");
    pulse(8'hFF);
    rd(12'hB04, 32'd0, 1'b0, "hpm4_none");

    wr(12'hB03, CSR_W, 32'hFFFF_FFFF);
    wr(12'hB83, CSR_W, 32'hFFFF_FFFF);
    rd(12'hB83, 32'hFFFF_FFFF, 1'b0, "hpm3_hi_wr");
    rd(12'hC03, 32'hFFFF_FFFF, 1'b0, "hpm3_lo_alias");
    pulse(8'h02);
    irq_m = 1'b1;
    rd(12'hB03, 32'd0, 1'b0, "wrap_lo");
    rd(12'hB83, 32'd0, 1'b0, "wrap_hi");
    rd(12'h7C0, 32'h8, 1'b0, "ovf_set");
    wr(12'h7C0, CSR_W, 32'h8);
    irq_m = 1'b0;
    rd(12'h7C0, 32'd0, 1'b0, "ovf_clr");

    wr(12'hB03, CSR_W, 32'hFFFF_FFFF);
    wr(12'hB83, CSR_W, 32'hFFFF_FFFF);
    cyc(12'h7C0, 1'b1, CSR_W, 32'h8, 8'h02, 1'b0, 1'b0, 32'd0, 1'b0, "");
    irq_m = 1'b1;
    rd(12'h7C0, 32'h8, 1'b0, "ovf_set_wins");
    rd(12'hC83, 32'd0, 1'b0, "wrap2_hi");
    wr(12'h7C0, CSR_W, 32'h8);
    irq_m = 1'b0;
    rd(12'h7C0, 32'd0, 1'b0, "ovf_clr2");

    wr(12'hB00, CSR_W, 32'h1234);
    rd(12'hB00, 32'h1234, 1'b0, "cyc_wr_lo");
    rd(12'hB80, 32'd0, 1'b0, "cyc_hi_hold");
    rd(12'hC00, 32'h1236, 1'b0, "cyc_resume");
    cyc(12'hC00, 1'b1, CSR_W, 32'd0, 8'd0, 1'b0, 1'b1,
        32'h1237, 1'b1, "ro_write");
    rd(12'hB00, 32'h1238, 1'b0, "ro_ignored");
    rd(12'hB0F, 32'd0, 1'b1, "unmapped_b0f");
    rd(12'hB01, 32'd0, 1'b1, "unmapped_time");
    rd(12'h327, 32'd0, 1'b1, "unmapped_evt");
    rd(12'hB07, 32'd0, 1'b1, "unmapped_b07");
    rd(12'hB86, 32'd0, 1'b0, "hpm6_hi");

    wr(12'hB83, CSR_W, 32'hABCD);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rd(12'hB83, 32'd0, 1'b0, "arst_hpm3_hi");
    rd(12'hB00, 32'd0, 1'b0, "arst_cycle");
    rd(12'h323, 32'd0, 1'b0, "arst_sel");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left: got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
